button_debounce_pair: RTL and testbench

//   Input conditioning stage that feeds the 2-input logic gates (and_gate etc.) from board push-buttons/switches.

---
 rtl/button_debounce_pair_if.sv | 23 ++
 rtl/button_debounce_pair.sv | 98 +++++++++
 tb/tb_button_debounce_pair.sv | 135 +++++++++++++
 3 files changed

// File: rtl/button_debounce_pair_if.sv
// Signal bundle between the board buttons and the debouncer.
// master: the side that drives raw levels and consumes the clean outputs.
// slave:  the debouncer itself.
interface button_debounce_pair_if;
  logic [1:0] btn_in;
  logic [1:0] sw_out;
  logic [1:0] rise;
  logic [1:0] fall;

  modport master (
    output btn_in,
    input  sw_out,
    input  rise,
    input  fall
  );

  modport slave (
    input  btn_in,
    output sw_out,
    output rise,
    output fall
  );
endinterface

// File: rtl/button_debounce_pair.sv
// Two-channel button synchroniser and debouncer.
// Each channel is synchronised, then has to stay stable for CNT_MAX edges before its
// clean level changes. One-cycle rise/fall pulses accompany each accepted change.
// sw_out[0] feeds gate input a, sw_out[1] feeds gate input b.
module button_debounce_pair #(
  parameter int unsigned CNT_MAX     = 250000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                   clk,
  input logic                   rst,
  button_debounce_pair_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  typedef enum logic [1:0] {StLo, StWaitHi, StHi, StWaitLo} state_e;

  for (genvar i = 0; i < 2; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_e                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   sw;
    logic                   rise;
    logic                   fall;

    assign s = sync[SYNC_STAGES-1];

    // Shift the raw level through the synchroniser chain.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync <= '0;
      end else begin
        sync <= {sync[SYNC_STAGES-2:0], bus.btn_in[i]};
      end
    end

    // Debounce FSM with registered level and edge pulses.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= StLo;
        cnt   <= '0;
        sw    <= 1'b0;
        rise  <= 1'b0;
        fall  <= 1'b0;
      end else begin
        rise <= 1'b0;
        fall <= 1'b0;
        case (state)
          StLo: begin
            if (s) begin
              state <= StWaitHi;
              cnt   <= '0;
            end
          end
          StWaitHi: begin
            // A return to the old level before the count completes is a glitch.
            if (!s) begin
              state <= StLo;
            end else if (cnt == CNT_LAST) begin
              state <= StHi;
              sw    <= 1'b1;
              rise  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          StHi: begin
            if (!s) begin
              state <= StWaitLo;
              cnt   <= '0;
            end
          end
          StWaitLo: begin
            if (s) begin
              state <= StHi;
            end else if (cnt == CNT_LAST) begin
              state <= StLo;
              sw    <= 1'b0;
              fall  <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= StLo;
          end
        endcase
      end
    end

    assign bus.sw_out[i] = sw;
    assign bus.rise[i]   = rise;
    assign bus.fall[i]   = fall;
  end

endmodule

// File: tb/tb_button_debounce_pair.sv
// Directed bench for button_debounce_pair with CNT_MAX=4, SYNC_STAGES=2.
// A level applied before edge 0 shows on sw_out after edge 6 (the 7th edge).
module tb_button_debounce_pair;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  button_debounce_pair_if bus_if ();

  button_debounce_pair #(
    .CNT_MAX    (4),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [1:0] btn;
    int         reps;
    logic [1:0] sw;
    logic [1:0] rise;
    logic [1:0] fall;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic [1:0] b, input int n,
                              input logic [1:0] esw, input logic [1:0] er,
                              input logic [1:0] ef);
    vec_t v;
    v.rst  = r;
    v.btn  = b;
    v.reps = n;
    v.sw   = esw;
    v.rise = er;
    v.fall = ef;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [1:0] esw, input logic [1:0] er,
                       input logic [1:0] ef);
    n_checks++;
    if ({bus_if.sw_out, bus_if.rise, bus_if.fall} !== {esw, er, ef}) begin
      n_fail++;
      $display("FAIL %s @%0t: got sw/rise/fall=%b/%b/%b expected %b/%b/%b", name, $time,
               bus_if.sw_out, bus_if.rise, bus_if.fall, esw, er, ef);
    end
  endtask

  // Drive inputs just after an edge, then sample 1 ns after the next edge.
  task automatic step(input logic r, input logic [1:0] b, input logic [1:0] esw,
                      input logic [1:0] er, input logic [1:0] ef, input string name);
    rst           = r;
    bus_if.btn_in = b;
    @(posedge clk);
    #1;
    check(name, esw, er, ef);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus_if.btn_in = 2'b11;

    // Reset held with buttons pressed, then release and accept both.
    add(1, 2'b11, 3, 2'b00, 2'b00, 2'b00);
    add(0, 2'b11, 6, 2'b00, 2'b00, 2'b00);
    add(0, 2'b11, 1, 2'b11, 2'b11, 2'b00);
    add(0, 2'b11, 3, 2'b11, 2'b00, 2'b00);
    // Both released together.
    add(0, 2'b00, 6, 2'b11, 2'b00, 2'b00);
    add(0, 2'b00, 1, 2'b00, 2'b00, 2'b11);
    add(0, 2'b00, 3, 2'b00, 2'b00, 2'b00);
    // Short press on channel 0 is rejected.
    add(0, 2'b01, 3, 2'b00, 2'b00, 2'b00);
    add(0, 2'b00, 10, 2'b00, 2'b00, 2'b00);
    // Walk 00,01,10,11,00; 01->10 gives simultaneous fall[0] and rise[1].
    add(0, 2'b00, 10, 2'b00, 2'b00, 2'b00);
    add(0, 2'b01, 6, 2'b00, 2'b00, 2'b00);
    add(0, 2'b01, 1, 2'b01, 2'b01, 2'b00);
    add(0, 2'b01, 3, 2'b01, 2'b00, 2'b00);
    add(0, 2'b10, 6, 2'b01, 2'b00, 2'b00);
    add(0, 2'b10, 1, 2'b10, 2'b10, 2'b01);
    add(0, 2'b10, 3, 2'b10, 2'b00, 2'b00);
    add(0, 2'b11, 6, 2'b10, 2'b00, 2'b00);
    add(0, 2'b11, 1, 2'b11, 2'b01, 2'b00);
    add(0, 2'b11, 3, 2'b11, 2'b00, 2'b00);
    add(0, 2'b00, 6, 2'b11, 2'b00, 2'b00);
    add(0, 2'b00, 1, 2'b00, 2'b00, 2'b11);
    add(0, 2'b00, 3, 2'b00, 2'b00, 2'b00);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int k = 0; k < vecs[i].reps; k++) begin
        step(vecs[i].rst, vecs[i].btn, vecs[i].sw, vecs[i].rise, vecs[i].fall,
             $sformatf("vec%0d.%0d", i, k));
      end
    end

    // Reset in the middle of a channel 1 wait restarts the whole acceptance.
    for (int k = 0; k < 4; k++) step(0, 2'b10, 2'b00, 2'b00, 2'b00, "mid_wait_pre");
    step(1, 2'b10, 2'b00, 2'b00, 2'b00, "mid_wait_rst");
    for (int k = 0; k < 6; k++) step(0, 2'b10, 2'b00, 2'b00, 2'b00, "mid_wait_hold");
    step(0, 2'b10, 2'b10, 2'b10, 2'b00, "mid_wait_rise");
    step(0, 2'b10, 2'b10, 2'b00, 2'b00, "mid_wait_after");

    // Channel 1 bouncing faster than the window keeps the accepted high level.
    for (int j = 0; j < 30; j++) begin
      step(0, (j % 3 == 2) ? 2'b10 : 2'b00, 2'b10, 2'b00, 2'b00, "bounce");
    end
    for (int k = 0; k < 6; k++) step(0, 2'b00, 2'b10, 2'b00, 2'b00, "settle_hold");
    step(0, 2'b00, 2'b00, 2'b00, 2'b10, "settle_fall");
    for (int k = 0; k < 2; k++) step(0, 2'b00, 2'b00, 2'b00, 2'b00, "settle_after");

    // Reset assertion clears outputs without waiting for a clock edge.
    for (int k = 0; k < 6; k++) step(0, 2'b11, 2'b00, 2'b00, 2'b00, "pre_async");
    step(0, 2'b11, 2'b11, 2'b11, 2'b00, "pre_async_rise");
    step(0, 2'b11, 2'b11, 2'b00, 2'b00, "pre_async_high");
    rst = 1'b1;
    #2;
    check("async_rst", 2'b00, 2'b00, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
